// File: rtl/mm_uart_rx_if.sv
// CPU-side memory-mapped bus bundle for the UART receive peripheral.
// The CPU drives address/strobes/write data; the peripheral returns read data.
interface mm_uart_rx_if;
    logic [15:0] addr;
    logic        mm_re;
    logic        mm_we;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (output addr, output mm_re, output mm_we, output wdata, input rdata);
    modport slave  (input addr, input mm_re, input mm_we, input wdata, output rdata);
endinterface

// File: rtl/mm_uart_rx.sv
// Memory-mapped 8N1 UART receiver: synchronised RX pin, bit-timing FSM, byte FIFO,
// and a combinational read decode for the data/status registers.
module mm_uart_rx #(
    parameter int          BAUD_DIV   = 434,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DATA_ADDR  = 16'hC004,
    parameter logic [15:0] STAT_ADDR  = 16'hC005
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RX,
    mm_uart_rx_if.slave     bus,
    output logic            rx_q_empty,
    output logic            rx_irq
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [11:0]      HALF_BIT = 12'(BAUD_DIV / 2);
    localparam logic [11:0]      FULL_M1  = 12'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nxt;
    logic [11:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        push_pend, push_pend_nxt;
    logic        frm_set;
    logic        rx_meta, rx_s;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, full, pop, push_ok, ovr_set;
    logic             overrun, frm_err;
    logic             ovr_clr, frm_clr;

    wire unused_wdata = ^{bus.wdata[15:4], bus.wdata[1:0]};

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            push_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            push_pend <= push_pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        push_pend_nxt = 1'b0;
        frm_set       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_nxt   = HALF_BIT;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt != 12'd0) begin
                    cnt_nxt = cnt - 12'd1;
                end else if (rx_s) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt     = FULL_M1;
                    bit_idx_nxt = 3'd0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (cnt != 12'd0) begin
                    cnt_nxt = cnt - 12'd1;
                end else begin
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    cnt_nxt     = FULL_M1;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt != 12'd0) begin
                    cnt_nxt = cnt - 12'd1;
                end else begin
                    if (rx_s) push_pend_nxt = 1'b1;
                    else      frm_set       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop     = bus.mm_re && (bus.addr == DATA_ADDR) && !empty;
    // A pop frees the slot in the same cycle, so a full queue can still accept.
    assign push_ok = push_pend && (!full || pop);
    assign ovr_set = push_pend && full && !pop;
    assign ovr_clr = bus.mm_we && (bus.addr == STAT_ADDR) && bus.wdata[2];
    assign frm_clr = bus.mm_we && (bus.addr == STAT_ADDR) && bus.wdata[3];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Set events take priority over a simultaneous software clear.
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
            if (frm_set)      frm_err <= 1'b1;
            else if (frm_clr) frm_err <= 1'b0;
        end
    end

    always_comb begin
        bus.rdata = 16'h0000;
        if (bus.mm_re) begin
            if (bus.addr == DATA_ADDR) begin
                if (!empty) bus.rdata = {8'h00, mem[rd_ptr]};
            end else if (bus.addr == STAT_ADDR) begin
                bus.rdata = {12'h000, frm_err, overrun, full, ~empty};
            end
        end
    end

    assign rx_q_empty = empty;
    assign rx_irq     = !empty || overrun || frm_err;
endmodule

// File: tb/tb_mm_uart_rx.sv
// Bench for mm_uart_rx: table of single frames plus hand-written overrun,
// glitch and mid-frame reset sequences, with a byte scoreboard queue.
module tb_mm_uart_rx;
    localparam int          BD    = 8;
    localparam int          DEPTH = 8;
    localparam logic [15:0] DA    = 16'hC004;
    localparam logic [15:0] SA    = 16'hC005;

    logic clk = 1'b0;
    logic rst;
    logic RX;
    logic rx_q_empty;
    logic rx_irq;

    mm_uart_rx_if bus();

    mm_uart_rx #(
        .BAUD_DIV(BD), .FIFO_DEPTH(DEPTH), .DATA_ADDR(DA), .STAT_ADDR(SA)
    ) dut (
        .clk(clk), .rst(rst), .RX(RX), .bus(bus),
        .rx_q_empty(rx_q_empty), .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        exp_empty;
        logic [15:0] exp_stat;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         m_count;
    logic       m_ovr;
    logic       m_frm;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        tick(BD);
    endtask

    // Drives a whole frame and records what the receiver should end up holding.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        RX = 1'b1;
        if (!stop) begin
            m_frm = 1'b1;
        end else if (m_count == DEPTH) begin
            m_ovr = 1'b1;
        end else begin
            exp_q.push_back(d);
            m_count++;
        end
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] r);
        bus.addr  = a;
        bus.mm_re = 1'b1;
        @(negedge clk);
        r = bus.rdata;
        @(posedge clk);
        #1;
        bus.mm_re = 1'b0;
        bus.addr  = 16'h0000;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.mm_we = 1'b1;
        tick(1);
        bus.mm_we = 1'b0;
        bus.addr  = 16'h0000;
        bus.wdata = 16'h0000;
    endtask

    task automatic read_expect_byte(input string name);
        logic [15:0] r;
        logic [7:0]  e;
        cpu_read(DA, r);
        if (exp_q.size() == 0) begin
            e = 8'h00;
        end else begin
            e = exp_q.pop_front();
            m_count--;
        end
        check(name, r, {8'h00, e});
    endtask

    function automatic logic [15:0] model_stat();
        return {12'h000, m_frm, m_ovr, (m_count == DEPTH), (m_count != 0)};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[5];
        logic [15:0] r;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 16'h0001};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 16'h0008};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 16'h0001};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 16'h0001};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 16'h0001};

        m_count   = 0;
        m_ovr     = 1'b0;
        m_frm     = 1'b0;
        rst       = 1'b1;
        RX        = 1'b1;
        bus.addr  = 16'h0000;
        bus.mm_re = 1'b0;
        bus.mm_we = 1'b0;
        bus.wdata = 16'h0000;
        tick(3);
        rst = 1'b0;
        tick(100);

        check("reset_empty", {15'h0, rx_q_empty}, 16'h0001);
        check("reset_irq", {15'h0, rx_irq}, 16'h0000);
        cpu_read(SA, r);
        check("reset_stat", r, 16'h0000);
        cpu_read(DA, r);
        check("reset_data_empty", r, 16'h0000);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            tick(10);
            check("vec_empty", {15'h0, rx_q_empty}, {15'h0, vecs[i].exp_empty});
            check("vec_irq", {15'h0, rx_irq}, 16'h0001);
            cpu_read(SA, r);
            check("vec_stat", r, vecs[i].exp_stat);
            if (vecs[i].stop) begin
                read_expect_byte("vec_data");
                check("vec_empty_after_pop", {15'h0, rx_q_empty}, 16'h0001);
            end else begin
                cpu_write(SA, 16'h0008);
                m_frm = 1'b0;
                cpu_read(SA, r);
                check("vec_frm_clear", r, 16'h0000);
            end
        end

        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1);
            tick(4);
        end
        tick(6);
        cpu_read(SA, r);
        check("ovr_stat", r, model_stat());
        cpu_read(SA, r);
        check("ovr_stat_reread", r, model_stat());
        cpu_read(16'hC006, r);
        check("other_addr", r, 16'h0000);
        cpu_write(DA, 16'h00FF);
        cpu_read(SA, r);
        check("data_write_ignored", r, model_stat());
        for (int i = 0; i < 9; i++) read_expect_byte("ovr_data");
        cpu_read(SA, r);
        check("ovr_stat_drained", r, model_stat());
        check("ovr_irq_sticky", {15'h0, rx_irq}, 16'h0001);
        cpu_write(SA, 16'h0004);
        m_ovr = 1'b0;
        cpu_read(SA, r);
        check("ovr_clear", r, 16'h0000);
        check("ovr_irq_clear", {15'h0, rx_irq}, 16'h0000);

        RX = 1'b0;
        tick(2);
        RX = 1'b1;
        tick(20);
        check("glitch_empty", {15'h0, rx_q_empty}, 16'h0001);
        cpu_read(SA, r);
        check("glitch_stat", r, 16'h0000);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        RX  = 1'b1;
        tick(20);
        check("midrst_empty", {15'h0, rx_q_empty}, 16'h0001);
        send_frame(8'h5A, 1'b1);
        tick(10);
        cpu_read(SA, r);
        check("midrst_stat", r, 16'h0001);
        read_expect_byte("midrst_data");
        check("midrst_empty_after", {15'h0, rx_q_empty}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
